// File: rtl/entropy_health_monitor.sv
// entropy_health_monitor: per-channel RCT/APT health tests with fault FSM and queued fault events
module entropy_health_monitor #(
  parameter int CHANNELS        = 4,
  parameter int RCT_CUTOFF      = 8,
  parameter int APT_WINDOW      = 128,
  parameter int APT_LOW         = 32,
  parameter int APT_HIGH        = 96,
  parameter int RECOVER_WINDOWS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] bit_in,
  input  logic [CHANNELS-1:0] bit_valid,
  input  logic                clear_faults,
  output logic [CHANNELS-1:0] ch_healthy,
  output logic                all_healthy,
  output logic                fault_valid,
  input  logic                fault_ready,
  output logic [3:0]          fault_channel,
  output logic [7:0]          fault_code,
  output logic [15:0]         fault_count
);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW + 1);
  typedef enum logic [1:0] {WARMUP, HEALTHY, FAULT, RECOVER} state_t;
  state_t              st_q    [CHANNELS];
  state_t              st_d    [CHANNELS];
  logic [RW-1:0]       run_q   [CHANNELS];
  logic [RW-1:0]       run_d   [CHANNELS];
  logic [AW-1:0]       smp_q   [CHANNELS];
  logic [AW-1:0]       smp_d   [CHANNELS];
  logic [AW-1:0]       ones_q  [CHANNELS];
  logic [AW-1:0]       ones_d  [CHANNELS];
  logic [AW-1:0]       tot     [CHANNELS];
  logic [3:0]          cln_q   [CHANNELS];
  logic [3:0]          cln_d   [CHANNELS];
  logic [7:0]          code    [CHANNELS];
  logic [7:0]          pcode_q [CHANNELS];
  logic [7:0]          pcode_d [CHANNELS];
  logic [CHANNELS-1:0] prev_q, prev_d, rwin_q, rwin_d, pend_q, pend_d, healthy_q;
  logic [CHANNELS-1:0] rct, lo, hi, fail, win_end, clean, evt, take;
  logic                all_q, fv_q, fv_d, free, any;
  logic [3:0]          sel, fch_q, fch_d;
  logic [7:0]          fcode_q, fcode_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [16:0]         sum;
  // run/window tests and per-channel state transitions; the run counter at 0 marks "no bit seen yet"
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      tot[c]     = ones_q[c] + AW'(bit_in[c]);
      win_end[c] = bit_valid[c] && smp_q[c] == AW'(APT_WINDOW - 1);
      rct[c]     = bit_valid[c] && bit_in[c] == prev_q[c] && run_q[c] == RW'(RCT_CUTOFF - 1);
      lo[c]      = win_end[c] && tot[c] < AW'(APT_LOW);
      hi[c]      = win_end[c] && tot[c] > AW'(APT_HIGH);
      fail[c]    = rct[c] || lo[c] || hi[c];
      clean[c]   = win_end[c] && !fail[c] && !rwin_q[c];
      evt[c]     = fail[c] && st_q[c] != FAULT;
      code[c]    = rct[c] ? 8'h01 : lo[c] ? 8'h02 : 8'h03;
      run_d[c]   = !bit_valid[c] ? run_q[c]
                 : (run_q[c] == '0 || bit_in[c] != prev_q[c]) ? RW'(1)
                 : run_q[c] == RW'(RCT_CUTOFF) ? run_q[c] : run_q[c] + RW'(1);
      prev_d[c]  = bit_valid[c] ? bit_in[c] : prev_q[c];
      smp_d[c]   = !bit_valid[c] ? smp_q[c] : win_end[c] ? '0 : smp_q[c] + AW'(1);
      ones_d[c]  = !bit_valid[c] ? ones_q[c] : win_end[c] ? '0 : tot[c];
      rwin_d[c]  = win_end[c] ? 1'b0 : rwin_q[c] | rct[c];
      st_d[c]    = fail[c] ? FAULT
                 : (st_q[c] == FAULT && clear_faults) ? RECOVER
                 : (clean[c] && (st_q[c] == WARMUP ||
                    (st_q[c] == RECOVER && cln_q[c] == 4'(RECOVER_WINDOWS - 1)))) ? HEALTHY
                 : st_q[c];
      cln_d[c]   = st_q[c] == FAULT ? 4'd0
                 : (st_q[c] == RECOVER && clean[c]) ? cln_q[c] + 4'd1 : cln_q[c];
    end
  end
  // pending slots, lowest-index arbitration into the output stage, saturating event count
  always_comb begin
    free    = !fv_q || fault_ready;
    any     = |pend_q;
    sel     = '0;
    take    = '0;
    fv_d    = free ? any : fv_q;
    fch_d   = fch_q;
    fcode_d = fcode_q;
    sum     = {1'b0, cnt_q};
    for (int c = CHANNELS - 1; c >= 0; c--) sel = pend_q[c] ? 4'(c) : sel;
    for (int c = 0; c < CHANNELS; c++) begin
      take[c]    = free && pend_q[c] && sel == 4'(c);
      fch_d      = take[c] ? 4'(c) : fch_d;
      fcode_d    = take[c] ? pcode_q[c] : fcode_d;
      pend_d[c]  = (pend_q[c] && !take[c]) || (evt[c] && !pend_q[c]);
      pcode_d[c] = (evt[c] && !pend_q[c]) ? code[c] : pcode_q[c];
      sum        = sum + 17'(evt[c]);
    end
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end
  // all state registers; health flags are registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        st_q[c]    <= WARMUP;
        run_q[c]   <= '0;
        smp_q[c]   <= '0;
        ones_q[c]  <= '0;
        cln_q[c]   <= '0;
        pcode_q[c] <= '0;
      end
      prev_q    <= '0;
      rwin_q    <= '0;
      pend_q    <= '0;
      healthy_q <= '0;
      all_q     <= 1'b0;
      fv_q      <= 1'b0;
      fch_q     <= '0;
      fcode_q   <= '0;
      cnt_q     <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        st_q[c]      <= st_d[c];
        run_q[c]     <= run_d[c];
        smp_q[c]     <= smp_d[c];
        ones_q[c]    <= ones_d[c];
        cln_q[c]     <= cln_d[c];
        pcode_q[c]   <= pcode_d[c];
        healthy_q[c] <= st_d[c] == HEALTHY;
      end
      prev_q  <= prev_d;
      rwin_q  <= rwin_d;
      pend_q  <= pend_d;
      all_q   <= &healthy_q;
      fv_q    <= fv_d;
      fch_q   <= fch_d;
      fcode_q <= fcode_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ch_healthy    = healthy_q;
  assign all_healthy   = all_q;
  assign fault_valid   = fv_q;
  assign fault_channel = fch_q;
  assign fault_code    = fcode_q;
  assign fault_count   = cnt_q;
endmodule

// File: tb/tb_entropy_health_monitor.sv
// tb_entropy_health_monitor: reference-model scoreboard bench for entropy_health_monitor
module tb_entropy_health_monitor;
  localparam int CH = 4, CUT = 8, WIN = 128, LO = 32, HI = 96, RWIN = 2;
  logic          clk = 1'b0, rst = 1'b1;
  logic [CH-1:0] bit_in = '0, bit_valid = '0;
  logic          clear_faults = 1'b0, fault_ready = 1'b1;
  logic [CH-1:0] ch_healthy;
  logic          all_healthy, fault_valid;
  logic [3:0]    fault_channel;
  logic [7:0]    fault_code;
  logic [15:0]   fault_count;
  entropy_health_monitor dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear_faults(clear_faults),
    .ch_healthy(ch_healthy), .all_healthy(all_healthy), .fault_valid(fault_valid),
    .fault_ready(fault_ready), .fault_channel(fault_channel), .fault_code(fault_code),
    .fault_count(fault_count)
  );
  always #5 clk = ~clk;
  typedef struct {int ch; int code;} ev_t;
  ev_t exp_q[$];
  int n_checks = 0, n_fail = 0, pos = 0;
  int m_st[CH], m_run[CH], m_prev[CH], m_smp[CH], m_ones[CH], m_rwin[CH], m_cln[CH], m_pcode[CH];
  bit m_pend[CH];
  bit [CH-1:0] m_h;
  bit m_all, m_fv;
  int m_fch, m_fcode, m_cnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_st[c] = 0; m_run[c] = 0; m_prev[c] = 0; m_smp[c] = 0; m_ones[c] = 0;
      m_rwin[c] = 0; m_cln[c] = 0; m_pcode[c] = 0; m_pend[c] = 0;
    end
    m_h = '0; m_all = 0; m_fv = 0; m_fch = 0; m_fcode = 0; m_cnt = 0;
    exp_q.delete();
  endtask
  // states: 0 warm-up, 1 healthy, 2 fault, 3 recover
  task automatic model_tick();
    bit [CH-1:0] ev, nh;
    int code[CH];
    bit old_pend[CH];
    int nev, found;
    nev = 0; found = -1;
    old_pend = m_pend;
    for (int c = 0; c < CH; c++) begin
      int nr, ones;
      bit b, rf, endw, lo, hi, f, clean;
      f = 0; clean = 0; code[c] = 0;
      if (bit_valid[c]) begin
        b = bit_in[c];
        nr = (m_run[c] == 0 || b != m_prev[c]) ? 1 : (m_run[c] + 1 > CUT ? CUT : m_run[c] + 1);
        rf = (nr == CUT) && (m_run[c] != CUT);
        endw = (m_smp[c] == WIN - 1);
        ones = m_ones[c] + b;
        lo = endw && ones < LO;
        hi = endw && ones > HI;
        f = rf || lo || hi;
        code[c] = rf ? 1 : (lo ? 2 : 3);
        clean = endw && !f && m_rwin[c] == 0;
        m_run[c] = nr; m_prev[c] = b;
        m_rwin[c] = endw ? 0 : (m_rwin[c] | rf);
        m_smp[c] = endw ? 0 : m_smp[c] + 1;
        m_ones[c] = endw ? 0 : ones;
      end
      ev[c] = f && m_st[c] != 2;
      case (m_st[c])
        0: if (f) m_st[c] = 2; else if (clean) m_st[c] = 1;
        1: if (f) m_st[c] = 2;
        2: if (!f && clear_faults) begin m_st[c] = 3; m_cln[c] = 0; end
        default: if (f) m_st[c] = 2;
                 else if (clean) begin m_cln[c]++; if (m_cln[c] == RWIN) m_st[c] = 1; end
      endcase
      nh[c] = m_st[c] == 1;
    end
    if (!m_fv || fault_ready) begin
      for (int c = 0; c < CH; c++) if (old_pend[c] && found < 0) found = c;
      if (found >= 0) begin
        m_fv = 1; m_fch = found; m_fcode = m_pcode[found]; m_pend[found] = 0;
        exp_q.push_back('{found, m_pcode[found]});
      end else m_fv = 0;
    end
    for (int c = 0; c < CH; c++) if (ev[c]) begin
      nev++;
      if (!old_pend[c]) begin m_pend[c] = 1; m_pcode[c] = code[c]; end
    end
    m_cnt = (m_cnt + nev > 65535) ? 65535 : m_cnt + nev;
    m_all = &m_h;
    m_h = nh;
  endtask
  task automatic compare_outputs();
    check("healthy", ch_healthy, m_h);
    check("all_healthy", all_healthy, m_all);
    check("fault_valid", fault_valid, m_fv);
    check("fault_count", fault_count, m_cnt);
    if (m_fv) begin
      check("out_chan", fault_channel, m_fch);
      check("out_code", fault_code, m_fcode);
    end
  endtask
  task automatic cyc();
    if (rst) model_reset();
    else begin
      if (fault_valid && fault_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", fault_valid, 0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          check("sb_chan", fault_channel, e.ch);
          check("sb_code", fault_code, e.code);
        end
      end
      model_tick();
    end
    @(posedge clk);
    #1;
    pos = rst ? 0 : (&bit_valid) ? (pos + 1) % WIN : pos;
    compare_outputs();
  endtask
  task automatic step(input logic [CH-1:0] ovr, input logic [CH-1:0] oval);
    bit_in = (oval & ovr) | ({CH{pos[0]}} & ~ovr);
    cyc();
  endtask
  function automatic logic pat(input int i, input int n);
    return (((i + 1) * n) / WIN - (i * n) / WIN) != 0;
  endfunction
  task automatic check_reset(input string tag);
    check({tag, "_healthy"}, ch_healthy, 0);
    check({tag, "_all"}, all_healthy, 0);
    check({tag, "_valid"}, fault_valid, 0);
    check({tag, "_chan"}, fault_channel, 0);
    check({tag, "_code"}, fault_code, 0);
    check({tag, "_count"}, fault_count, 0);
  endtask
  initial begin
    logic [CH-1:0] cur;
    cur = '0;
    cyc(); cyc();
    check_reset("reset");
    rst = 1'b0; bit_valid = '1;
    repeat (WIN) step('0, '0);
    check("warm_healthy", ch_healthy, 4'hF);
    check("warm_all_lag", all_healthy, 0);
    step('0, '0);
    check("warm_all", all_healthy, 1);
    check("warm_no_event", fault_count, 0);
    repeat (8) step(4'b0100, 4'b0100);
    check("rct_healthy2", ch_healthy[2], 0);
    step('0, '0);
    check("rct_valid", fault_valid, 1);
    check("rct_chan", fault_channel, 2);
    check("rct_code", fault_code, 1);
    check("rct_count", fault_count, 1);
    while (pos != 0) step('0, '0);
    for (int i = 0; i < WIN; i++) step(4'b0001, {3'b0, pat(i, 20)});
    check("apt_lo_healthy0", ch_healthy[0], 0);
    clear_faults = 1'b1;
    step(4'b0001, {3'b0, pat(0, 32)});
    clear_faults = 1'b0;
    check("apt_lo_valid", fault_valid, 1);
    check("apt_lo_chan", fault_channel, 0);
    check("apt_lo_code", fault_code, 2);
    for (int i = 1; i < WIN; i++) step(4'b0001, {3'b0, pat(i, 32)});
    check("recover_one_window", ch_healthy, 4'b1010);
    for (int i = 0; i < WIN; i++) step(4'b0001, {3'b0, pat(i, 96)});
    check("recover_two_windows", ch_healthy, 4'hF);
    for (int i = 0; i < WIN; i++) step(4'b0001, {3'b0, pat(i, 100)});
    check("apt_hi_healthy0", ch_healthy[0], 0);
    step('0, '0);
    check("apt_hi_code", fault_code, 3);
    check("apt_hi_count", fault_count, 3);
    repeat (4) step('0, '0);
    fault_ready = 1'b0;
    repeat (8) step(4'b1010, 4'b1010);
    check("dual_healthy", ch_healthy, 4'b0100);
    for (int i = 0; i < 10; i++) begin
      step('0, '0);
      check("hold_valid", fault_valid, 1);
      check("hold_chan", fault_channel, 1);
      check("hold_code", fault_code, 1);
    end
    fault_ready = 1'b1;
    step('0, '0);
    check("next_chan", fault_channel, 3);
    check("next_valid", fault_valid, 1);
    step('0, '0);
    check("drained_valid", fault_valid, 0);
    check("dual_count", fault_count, 5);
    while (pos != 0) step('0, '0);
    clear_faults = 1'b1;
    step('0, '0);
    clear_faults = 1'b0;
    repeat (9) step('0, '0);
    repeat (8) step(4'b0010, 4'b0010);
    step('0, '0); step('0, '0);
    check("refault_healthy1", ch_healthy[1], 0);
    check("refault_count", fault_count, 6);
    fault_ready = 1'b0;
    repeat (8) step(4'b0100, 4'b0100);
    check("pre_rst_valid", fault_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; fault_ready = 1'b1;
    check_reset("midrst");
    repeat (WIN - 1) step('0, '0);
    check("rewarm_pending", ch_healthy, 0);
    step('0, '0);
    check("rewarm_healthy", ch_healthy, 4'hF);
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 2) == 0) cur[c] = ~cur[c];
      for (int c = 0; c < CH; c++) bit_valid[c] = $urandom_range(0, 7) != 0;
      fault_ready = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      clear_faults = $urandom_range(0, 39) == 0;
      bit_in = cur;
      cyc();
    end
    clear_faults = 1'b0; bit_valid = '0; fault_ready = 1'b1;
    repeat (10) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
